// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - parallel request / serial line bundle for uart_tx
// master drives the request side, slave (the transmitter) drives TX_OUT and BUSY.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, BUSY
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, BUSY
  );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame serializer, one bit per CLK, optional parity
// Define UART_TX_HOLD_EN to add a one-entry holding register for back-to-back frames.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  accept;

`ifdef UART_TX_HOLD_EN
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_en_q, hold_en_d;
  logic                  hold_typ_q, hold_typ_d;
  logic                  hold_full_q, hold_full_d;
  logic                  direct;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

`ifdef UART_TX_HOLD_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_data_q <= '0;
      hold_en_q   <= 1'b0;
      hold_typ_q  <= 1'b0;
      hold_full_q <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_en_q   <= hold_en_d;
      hold_typ_q  <= hold_typ_d;
      hold_full_q <= hold_full_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
`ifdef UART_TX_HOLD_EN
    hold_data_d = hold_data_q;
    hold_en_d   = hold_en_q;
    hold_typ_d  = hold_typ_q;
    hold_full_d = hold_full_q;
    // The slot frees up in the STOP cycle it drains, so a request then still fits.
    accept = bus.DATA_VALID && (!busy_q || (state_q == STOP && hold_full_q));
    direct = (state_q == IDLE) || (state_q == STOP && !hold_full_q);
`else
    accept = bus.DATA_VALID && !busy_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
        state_d = IDLE;
`ifdef UART_TX_HOLD_EN
        if (hold_full_q) begin
          state_d     = START;
          data_d      = hold_data_q;
          par_en_d    = hold_en_q;
          par_typ_d   = hold_typ_q;
          hold_full_d = 1'b0;
        end else if (accept) begin
          state_d   = START;
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_TX_HOLD_EN
    if (accept && !direct) begin
      hold_data_d = bus.P_DATA;
      hold_en_d   = bus.PAR_EN;
      hold_typ_d  = bus.PAR_TYP;
      hold_full_d = 1'b1;
    end
    busy_d = hold_full_d;
`else
    busy_d = (state_d != IDLE);
`endif

    // Line level is computed from the next state so TX_OUT is a plain flop.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[cnt_d];
      PARITY:  tx_d = (^data_d) ^ par_typ_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.TX_OUT = tx_q;
  assign bus.BUSY   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (default build or UART_TX_HOLD_EN)
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();
  uart_tx #(.DATA_WIDTH(8)) dut (.CLK(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        pen;
    logic        ptyp;
    logic [10:0] frame;
    int          len;
  } vec_t;

`ifdef UART_TX_HOLD_EN
  localparam logic FRAME_BUSY = 1'b0;
`else
  localparam logic FRAME_BUSY = 1'b1;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.BUSY !== 1'b0 || dut.state_q != dut.IDLE) && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptyp, input int len,
                           output logic [10:0] bits, output logic busy_ok, output logic idle_ok);
    bits = '0;
    busy_ok = 1'b1;
    bus.P_DATA = d; bus.PAR_EN = pen; bus.PAR_TYP = ptyp; bus.DATA_VALID = 1'b1;
    step();
    bus.DATA_VALID = 1'b0;
    for (int i = 0; i < len; i++) begin
      bus.P_DATA = 8'($urandom); bus.PAR_EN = 1'($urandom); bus.PAR_TYP = 1'($urandom);
      bits[i] = bus.TX_OUT;
      if (bus.BUSY !== FRAME_BUSY) busy_ok = 1'b0;
      step();
    end
    idle_ok = (bus.TX_OUT === 1'b1) && (bus.BUSY === 1'b0);
  endtask

  vec_t vecs[7];
  logic [10:0] bits;
  logic busy_ok, idle_ok;
  bit   mq[$];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, {1'b0, 1'b1, 8'hA5, 1'b0}, 10};
    vecs[1] = '{8'h03, 1'b1, 1'b0, {1'b1, 1'b0, 8'h03, 1'b0}, 11};
    vecs[2] = '{8'h03, 1'b1, 1'b1, {1'b1, 1'b1, 8'h03, 1'b0}, 11};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, {1'b0, 1'b1, 8'hFF, 1'b0}, 10};
    vecs[4] = '{8'h00, 1'b1, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 11};
    vecs[5] = '{8'h80, 1'b1, 1'b1, {1'b1, 1'b0, 8'h80, 1'b0}, 11};
    vecs[6] = '{8'h01, 1'b1, 1'b0, {1'b1, 1'b1, 8'h01, 1'b0}, 11};

    bus.P_DATA = '0; bus.DATA_VALID = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    repeat (2) step();
    check("reset_tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, bus.BUSY}, 32'd0);
    rst = 1'b0;
    repeat (3) step();
    check("post_reset_idle", {30'd0, bus.TX_OUT, bus.BUSY}, 32'd2);

    foreach (vecs[k]) begin
      run_frame(vecs[k].data, vecs[k].pen, vecs[k].ptyp, vecs[k].len, bits, busy_ok, idle_ok);
      check($sformatf("vec%0d_frame", k), {21'd0, bits}, {21'd0, vecs[k].frame});
      check($sformatf("vec%0d_busy", k), {31'd0, busy_ok}, 32'd1);
      check($sformatf("vec%0d_idle_after", k), {31'd0, idle_ok}, 32'd1);
      step();
    end

    // Reset mid-frame: line goes high without any clock edge.
    bus.P_DATA = 8'h00; bus.PAR_EN = 1'b0; bus.DATA_VALID = 1'b1;
    step();
    bus.DATA_VALID = 1'b0;
    repeat (4) step();
    check("pre_reset_bit", {31'd0, bus.TX_OUT}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("async_reset_busy", {31'd0, bus.BUSY}, 32'd0);
    step();
    rst = 1'b0;
    repeat (2) step();
    check("after_release_idle", {30'd0, bus.TX_OUT, bus.BUSY}, 32'd2);
    run_frame(8'h5A, 1'b0, 1'b0, 10, bits, busy_ok, idle_ok);
    check("clean_frame_after_reset", {21'd0, bits}, {22'd0, 1'b1, 8'h5A, 1'b0});

`ifdef UART_TX_HOLD_EN
    wait_idle();
    bus.P_DATA = 8'h55; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.DATA_VALID = 1'b1;
    step();
    bits = '0;
    begin
      logic [19:0] line = '0;
      for (int i = 0; i < 20; i++) begin
        bus.DATA_VALID = (i == 0) || (i == 2);
        bus.P_DATA = (i == 0) ? 8'hAA : 8'h0F;
        if (i == 0) check("hold_busy_empty", {31'd0, bus.BUSY}, 32'd0);
        if (i == 2) check("hold_busy_full", {31'd0, bus.BUSY}, 32'd1);
        line[i] = bus.TX_OUT;
        step();
      end
      bus.DATA_VALID = 1'b0;
      check("hold_back_to_back", {12'd0, line}, {12'd0, 1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0});
      line = '0;
      for (int i = 0; i < 12; i++) begin
        line[i] = bus.TX_OUT;
        step();
      end
      check("hold_third_dropped", {20'd0, line[11:0]}, 32'hFFF);
    end
`else
    // A request mid-frame must be ignored.
    wait_idle();
    bits = '0;
    bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b0; bus.DATA_VALID = 1'b1;
    step();
    for (int i = 0; i < 13; i++) begin
      bus.DATA_VALID = (i == 3);
      bus.P_DATA = (i == 3) ? 8'hFF : 8'h3C;
      if (i < 11) bits[i] = bus.TX_OUT;
      else check($sformatf("ignored_req_idle%0d", i), {30'd0, bus.TX_OUT, bus.BUSY}, 32'd2);
      step();
    end
    bus.DATA_VALID = 1'b0;
    check("ignored_req_frame", {21'd0, bits}, {20'd0, 1'b1, 1'b1, 8'h3C, 1'b0});

    // Random traffic against a bit-queue model of the serial line.
    wait_idle();
    for (int c = 0; c < 600; c++) begin
      logic et, eb;
      logic [7:0] d;
      logic dv, pe, pt;
      if (mq.size() > 0) begin et = mq.pop_front(); eb = 1'b1; end
      else begin et = 1'b1; eb = 1'b0; end
      check("rand_tx", {31'd0, bus.TX_OUT}, {31'd0, et});
      check("rand_busy", {31'd0, bus.BUSY}, {31'd0, eb});
      dv = ($urandom_range(0, 2) == 0);
      d = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
      bus.DATA_VALID = dv; bus.P_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt;
      if (dv && !eb) begin
        mq.push_back(1'b0);
        for (int b = 0; b < 8; b++) mq.push_back(d[b]);
        if (pe) mq.push_back(pt ? ~(^d) : ^d);
        mq.push_back(1'b1);
      end
      step();
    end
    bus.DATA_VALID = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame.
REQ-002 SHALL have port CLK  input  1  bit-rate clock; one serial bit is emitted per CLK cycle.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel byte to transmit.
REQ-005 SHALL have port DATA_VALID  input  1  single-cycle request; P_DATA is valid this cycle.
REQ-006 SHALL have port PAR_EN  input  1  1 = parity bit inserted after the data bits.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port TX_OUT  output  1  serial line, registered, idle high.
REQ-009 SHALL have port BUSY  output  1  registered; 1 = a DATA_VALID this cycle is not accepted.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL accept a request when DATA_VALID=1 and BUSY=0; P_DATA, PAR_EN and PAR_TYP are latched in that same cycle.
REQ-012 SHALL ignore DATA_VALID while BUSY=1, with no state change and no latch.
REQ-013 SHALL, on accept in cycle N, drive TX_OUT=0 (start bit) in cycle N+1; latency is 1 cycle.
REQ-014 SHALL send the DATA state LSB first, one bit per cycle for DATA_WIDTH cycles, counted by an internal bit counter that wraps to 0 on leaving DATA.
REQ-015 SHALL, when the latched PAR_EN=1, send a PARITY state bit equal to XOR of the latched data for even parity and its complement for odd parity.
REQ-016 SHALL skip PARITY when the latched PAR_EN=0, going from DATA directly to STOP.
REQ-017 SHALL drive TX_OUT=1 for exactly one cycle in STOP.
REQ-018 SHALL give a frame length of 1+DATA_WIDTH+PAR_EN+1 cycles (10 or 11 for DATA_WIDTH=8).
REQ-019 SHALL hold TX_OUT=1 in IDLE.
REQ-020 SHALL drive BUSY=1 from the cycle after accept through the STOP cycle inclusive, and BUSY=0 in IDLE; this applies without the macro.
REQ-021 SHALL use only latched copies of the inputs during a frame, so changes to P_DATA, PAR_EN or PAR_TYP mid-frame have no effect.
REQ-022 SHALL, without the macro, leave at least one IDLE cycle (TX_OUT=1) between consecutive frames.

Reset
REQ-023 SHALL, while RST=1 at any time including mid-frame, immediately force TX_OUT=1, BUSY=0, state=IDLE, bit counter=0, and all latched data and parity registers to 0.
REQ-024 SHALL leave IDLE only on an accepted DATA_VALID in the first rising CLK edge after RST deasserts.

Configuration
REQ-025 SHALL use macro UART_TX_HOLD_EN to compile in a one-entry holding register.
REQ-026 SHALL, with UART_TX_HOLD_EN defined, accept DATA_VALID while a frame is in progress if the holding register is empty, storing P_DATA, PAR_EN and PAR_TYP there.
REQ-027 SHALL, with UART_TX_HOLD_EN defined, drive BUSY=1 only when the holding register is full.
REQ-028 SHALL, with UART_TX_HOLD_EN defined and the holding register full at STOP, go from STOP directly to START with the held byte in the next cycle (no idle cycle) and clear the holding register.
REQ-029 SHALL, with UART_TX_HOLD_EN defined, treat DATA_VALID in the same cycle the holding register empties into the shifter as accepted into the holding register.
REQ-030 SHALL, without UART_TX_HOLD_EN, contain no holding register, and behaviour follows REQ-020 and REQ-022 exactly.

Verification
REQ-031 SHALL cover: PAR_EN=0, P_DATA=8'hA5, DATA_VALID pulse at cycle 0 -> TX_OUT from cycle 1 = 0,1,0,1,0,0,1,0,1,1 then idle 1; BUSY high in cycles 1-10.
REQ-032 SHALL cover: PAR_EN=1, PAR_TYP=0, P_DATA=8'h03 -> parity bit 0 at cycle 10, stop bit at cycle 11; same with PAR_TYP=1 -> parity bit 1.
REQ-033 SHALL cover: DATA_VALID with P_DATA=8'hFF asserted at cycle 4 of an active frame, no macro -> ignored; TX_OUT carries only the first frame.
REQ-034 SHALL cover: RST asserted at cycle 5 of a frame -> TX_OUT=1 and BUSY=0 asynchronously; the next DATA_VALID after release starts a clean frame.
REQ-035 SHALL cover: with UART_TX_HOLD_EN, 8'h55 then 8'hAA accepted one cycle apart -> 20 contiguous frame bits with no idle bit between the two frames; a third request while the holding register is full sees BUSY=1 and is dropped.
